// File: rtl/reg_bank_sb_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reg_bank_if: read, write, reserve and debug signals of reg_bank_sb
// Rev 1.0
// ----------------------------------------------------------------------------
interface reg_bank_if #(
  parameter int DW = 32,
  parameter int AW = 4
);
  logic [AW-1:0]      rad1;
  logic               ren1;
  logic [DW-1:0]      rdata1;
  logic               busy1;
  logic [AW-1:0]      rad2;
  logic               ren2;
  logic [DW-1:0]      rdata2;
  logic               busy2;
  logic               wen;
  logic [AW-1:0]      wad;
  logic [DW-1:0]      wdata;
  logic               resv_en;
  logic [AW-1:0]      resv_ad;
  logic [AW-1:0]      dbg_ad;
  logic [DW-1:0]      dbg_data;
  logic [(1<<AW)-1:0] busy_vec;

  modport master (
    output rad1, ren1, rad2, ren2, wen, wad, wdata, resv_en, resv_ad, dbg_ad,
    input  rdata1, busy1, rdata2, busy2, dbg_data, busy_vec
  );

  modport slave (
    input  rad1, ren1, rad2, ren2, wen, wad, wdata, resv_en, resv_ad, dbg_ad,
    output rdata1, busy1, rdata2, busy2, dbg_data, busy_vec
  );
endinterface
`default_nettype wire

// File: rtl/reg_bank_sb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reg_bank_sb: 2R/1W register bank with write bypass and busy scoreboard
// Rev 1.0
// ----------------------------------------------------------------------------
module reg_bank_sb #(
  parameter int DW      = 32,
  parameter int AW      = 4,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 1
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  reg_bank_if.slave   bus
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic             wr_legal;
  logic             fwd1;
  logic             fwd2;

  // Writes to r0 are dropped entirely when it is hardwired, including the bypass path.
  assign wr_legal = bus.wen && ((ZERO_R0 == 0) || (bus.wad != '0));
  assign fwd1     = (BYPASS != 0) && wr_legal && (bus.wad == bus.rad1);
  assign fwd2     = (BYPASS != 0) && wr_legal && (bus.wad == bus.rad2);

  always_comb begin
    bus.rdata1 = '0;
    bus.busy1  = 1'b0;
    if (bus.ren1) begin
      bus.rdata1 = fwd1 ? bus.wdata : mem[bus.rad1];
      bus.busy1  = busy[bus.rad1] && !fwd1;
    end
  end

  always_comb begin
    bus.rdata2 = '0;
    bus.busy2  = 1'b0;
    if (bus.ren2) begin
      bus.rdata2 = fwd2 ? bus.wdata : mem[bus.rad2];
      bus.busy2  = busy[bus.rad2] && !fwd2;
    end
  end

  assign bus.dbg_data = mem[bus.dbg_ad];
  assign bus.busy_vec = busy;

  // Reservation is applied after the writeback clear so a back-to-back producer stays busy.
  always_comb begin
    busy_nxt = busy;
    if (bus.wen) begin
      busy_nxt[bus.wad] = 1'b0;
    end
    if (bus.resv_en) begin
      busy_nxt[bus.resv_ad] = 1'b1;
    end
    if (ZERO_R0 != 0) begin
      busy_nxt[0] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      busy <= '0;
    end else begin
      if (wr_legal) begin
        mem[bus.wad] <= bus.wdata;
      end
      busy <= busy_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_sb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_reg_bank_sb: scoreboard bench for reg_bank_sb, bypass and no-bypass builds
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_reg_bank_sb;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    logic          rst_n;
    logic [AW-1:0] rad1, rad2, wad, resv_ad, dbg_ad;
    logic          ren1, ren2, wen, resv_en;
    logic [DW-1:0] wdata;
  } stim_t;

  typedef struct {
    logic [DW-1:0]    rdata1, rdata2, dbg;
    logic             busy1, busy2;
    logic [DEPTH-1:0] bv;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_bank_if #(.DW(DW), .AW(AW)) bus_b ();
  reg_bank_if #(.DW(DW), .AW(AW)) bus_n ();

  reg_bank_sb #(.DW(DW), .AW(AW), .BYPASS(1), .ZERO_R0(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );
  reg_bank_sb #(.DW(DW), .AW(AW), .BYPASS(0), .ZERO_R0(1)) dut_n (
    .clk(clk), .rst_n(rst_n), .bus(bus_n)
  );

  // The no-bypass build sees exactly the same stimulus.
  assign bus_n.rad1    = bus_b.rad1;
  assign bus_n.ren1    = bus_b.ren1;
  assign bus_n.rad2    = bus_b.rad2;
  assign bus_n.ren2    = bus_b.ren2;
  assign bus_n.wen     = bus_b.wen;
  assign bus_n.wad     = bus_b.wad;
  assign bus_n.wdata   = bus_b.wdata;
  assign bus_n.resv_en = bus_b.resv_en;
  assign bus_n.resv_ad = bus_b.resv_ad;
  assign bus_n.dbg_ad  = bus_b.dbg_ad;

  logic [DW-1:0]    m_mem [DEPTH];
  logic [DEPTH-1:0] m_busy;
  exp_t             q_b[$];
  exp_t             q_n[$];
  int               total = 0;
  int               bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst_n = 1'b1; s.rad1 = '0; s.rad2 = '0; s.wad = '0; s.resv_ad = '0;
    s.dbg_ad = '0; s.ren1 = 1'b0; s.ren2 = 1'b0; s.wen = 1'b0;
    s.resv_en = 1'b0; s.wdata = '0;
    return s;
  endfunction

  function automatic exp_t predict(input stim_t s, input bit byp);
    exp_t e;
    logic legal;
    legal = s.wen && (s.wad != 0);
    e.rdata1 = '0; e.busy1 = 1'b0; e.rdata2 = '0; e.busy2 = 1'b0;
    if (s.ren1) begin
      if (byp && legal && s.wad == s.rad1) e.rdata1 = s.wdata;
      else begin e.rdata1 = m_mem[s.rad1]; e.busy1 = m_busy[s.rad1]; end
    end
    if (s.ren2) begin
      if (byp && legal && s.wad == s.rad2) e.rdata2 = s.wdata;
      else begin e.rdata2 = m_mem[s.rad2]; e.busy2 = m_busy[s.rad2]; end
    end
    e.dbg = m_mem[s.dbg_ad];
    e.bv  = m_busy;
    return e;
  endfunction

  task automatic compare();
    exp_t e;
    if (q_b.size() == 0 || q_n.size() == 0) begin
      check("sb_queue_empty", 64'(q_b.size() + q_n.size()), 64'd2);
      return;
    end
    e = q_b.pop_front();
    check("byp.rdata1", bus_b.rdata1, e.rdata1);
    check("byp.busy1",  bus_b.busy1,  e.busy1);
    check("byp.rdata2", bus_b.rdata2, e.rdata2);
    check("byp.busy2",  bus_b.busy2,  e.busy2);
    check("byp.dbg",    bus_b.dbg_data, e.dbg);
    check("byp.bvec",   bus_b.busy_vec, e.bv);
    e = q_n.pop_front();
    check("nob.rdata1", bus_n.rdata1, e.rdata1);
    check("nob.busy1",  bus_n.busy1,  e.busy1);
    check("nob.rdata2", bus_n.rdata2, e.rdata2);
    check("nob.busy2",  bus_n.busy2,  e.busy2);
    check("nob.dbg",    bus_n.dbg_data, e.dbg);
    check("nob.bvec",   bus_n.busy_vec, e.bv);
  endtask

  // Drive on the falling edge, then score the combinational outputs mid-cycle.
  task automatic drive(input stim_t s, input bit chk);
    @(negedge clk);
    rst_n         = s.rst_n;
    bus_b.rad1    = s.rad1;   bus_b.ren1 = s.ren1;
    bus_b.rad2    = s.rad2;   bus_b.ren2 = s.ren2;
    bus_b.wen     = s.wen;    bus_b.wad  = s.wad;  bus_b.wdata = s.wdata;
    bus_b.resv_en = s.resv_en; bus_b.resv_ad = s.resv_ad;
    bus_b.dbg_ad  = s.dbg_ad;
    #1;
    if (chk) begin
      q_b.push_back(predict(s, 1'b1));
      q_n.push_back(predict(s, 1'b0));
      compare();
    end
  endtask

  task automatic tick(input stim_t s);
    @(posedge clk);
    if (!s.rst_n) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_busy = '0;
    end else begin
      if (s.wen && s.wad != 0) m_mem[s.wad] = s.wdata;
      if (s.wen) m_busy[s.wad] = 1'b0;
      if (s.resv_en && s.resv_ad != 0) m_busy[s.resv_ad] = 1'b1;
    end
    #1;
  endtask

  initial begin
    stim_t s;
    s = idle(); s.rst_n = 1'b0;
    drive(s, 1'b0); tick(s);

    // Reset clears data and pending reservations.
    s = idle(); s.wen = 1'b1; s.wad = 4'd5; s.wdata = 32'hDEADBEEF;
    s.resv_en = 1'b1; s.resv_ad = 4'd6;
    drive(s, 1'b1); tick(s);
    s = idle(); s.rst_n = 1'b0; s.rad1 = 4'd5; s.ren1 = 1'b1;
    drive(s, 1'b1); tick(s);
    check("t1_rdata1_r5", bus_b.rdata1, 64'd0);
    check("t1_busy_vec", bus_b.busy_vec, 64'd0);

    // Same-cycle bypass versus registered-only read.
    s = idle(); s.wen = 1'b1; s.wad = 4'd3; s.wdata = 32'h11;
    drive(s, 1'b1); tick(s);
    s = idle(); s.wen = 1'b1; s.wad = 4'd3; s.wdata = 32'h12345678;
    s.rad1 = 4'd3; s.ren1 = 1'b1;
    drive(s, 1'b1);
    check("t2_byp_rdata1", bus_b.rdata1, 64'h12345678);
    check("t2_nob_rdata1_old", bus_n.rdata1, 64'h11);
    tick(s);
    check("t2_nob_rdata1_new", bus_n.rdata1, 64'h12345678);

    // Hardwired r0.
    s = idle(); s.wen = 1'b1; s.wad = 4'd0; s.wdata = 32'hFFFFFFFF;
    s.rad1 = 4'd0; s.ren1 = 1'b1;
    drive(s, 1'b1);
    check("t3_r0_no_bypass", bus_b.rdata1, 64'd0);
    tick(s);
    s = idle(); s.resv_en = 1'b1; s.resv_ad = 4'd0; s.rad1 = 4'd0; s.ren1 = 1'b1;
    drive(s, 1'b1); tick(s);
    check("t3_r0_rdata1", bus_b.rdata1, 64'd0);
    check("t3_r0_busy", bus_b.busy_vec[0], 64'd0);
    check("t3_r0_dbg", bus_b.dbg_data, 64'd0);

    // Reserve r7, hold busy for cycles 1..3, release by writeback in cycle 4.
    s = idle(); s.resv_en = 1'b1; s.resv_ad = 4'd7; s.rad1 = 4'd7; s.ren1 = 1'b1;
    drive(s, 1'b1); tick(s);
    for (int c = 1; c <= 3; c++) begin
      s = idle(); s.rad1 = 4'd7; s.ren1 = 1'b1;
      drive(s, 1'b1);
      check("t4_busy1_held", bus_b.busy1, 64'd1);
      tick(s);
    end
    s = idle(); s.wen = 1'b1; s.wad = 4'd7; s.wdata = 32'hA5; s.rad1 = 4'd7; s.ren1 = 1'b1;
    drive(s, 1'b1);
    check("t4_byp_busy1", bus_b.busy1, 64'd0);
    check("t4_byp_rdata1", bus_b.rdata1, 64'hA5);
    check("t4_nob_busy1", bus_n.busy1, 64'd1);
    tick(s);
    check("t4_busy_vec7", bus_b.busy_vec[7], 64'd0);

    // Write and reserve the same register: data lands, reservation wins.
    s = idle(); s.wen = 1'b1; s.wad = 4'd9; s.wdata = 32'hCAFE0009;
    s.resv_en = 1'b1; s.resv_ad = 4'd9; s.dbg_ad = 4'd9;
    drive(s, 1'b1); tick(s);
    check("t5_busy_vec9", bus_b.busy_vec[9], 64'd1);
    check("t5_dbg_r9", bus_b.dbg_data, 64'hCAFE0009);

    // Disabled read ports mask data and busy.
    s = idle(); s.resv_en = 1'b1; s.resv_ad = 4'd4;
    drive(s, 1'b1); tick(s);
    s = idle(); s.rad1 = 4'd4; s.rad2 = 4'd4;
    drive(s, 1'b1);
    check("t6_rdata1", bus_b.rdata1, 64'd0);
    check("t6_rdata2", bus_b.rdata2, 64'd0);
    check("t6_busy1", bus_b.busy1, 64'd0);
    check("t6_busy2", bus_b.busy2, 64'd0);
    check("t6_busy_vec4", bus_b.busy_vec[4], 64'd1);
    tick(s);

    // Random traffic on a narrow address range to provoke collisions.
    for (int n = 0; n < 300; n++) begin
      s = idle();
      s.rst_n   = ($urandom_range(0, 99) != 0);
      s.rad1    = AW'($urandom_range(0, 5));
      s.rad2    = AW'($urandom_range(0, 5));
      s.ren1    = ($urandom_range(0, 3) != 0);
      s.ren2    = ($urandom_range(0, 3) != 0);
      s.wen     = $urandom_range(0, 1) == 1;
      s.wad     = AW'($urandom_range(0, 5));
      s.wdata   = $urandom;
      s.resv_en = $urandom_range(0, 1) == 1;
      s.resv_ad = AW'($urandom_range(0, 5));
      s.dbg_ad  = AW'($urandom_range(0, DEPTH - 1));
      drive(s, 1'b1); tick(s);
    end

    check("sb_drained", 64'(q_b.size() + q_n.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
